// File: rtl/vape_exec_monitor_if.sv
// vape_exec_monitor_if: CPU/DMA observation bus into the execution monitor and its abort outputs
interface vape_exec_monitor_if;
    logic [15:0] pc;
    logic        irq;
    logic        data_wr;
    logic [15:0] data_addr;
    logic        dma_en;
    logic [15:0] dma_addr;
    logic [15:0] ER_min;
    logic [15:0] ER_max;
    logic [15:0] OR_min;
    logic [15:0] OR_max;
    logic        viol;
    logic        in_er;
    logic [2:0]  viol_cause;

    modport master (
        output pc, irq, data_wr, data_addr, dma_en, dma_addr, ER_min, ER_max, OR_min, OR_max,
        input  viol, in_er, viol_cause
    );
    modport slave (
        input  pc, irq, data_wr, data_addr, dma_en, dma_addr, ER_min, ER_max, OR_min, OR_max,
        output viol, in_er, viol_cause
    );
endinterface

// File: rtl/vape_exec_monitor.sv
// vape_exec_monitor: flags non-atomic or tampered execution of the attested region and drives a stretched abort pulse
module vape_exec_monitor #(
    parameter int ABORT_CYCLES = 4
) (
    input logic clk,
    input logic reset_n,
    vape_exec_monitor_if.slave bus
);
    localparam int CW = $clog2(ABORT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, RUN, KILL} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [15:0] pc_prev;
    logic [2:0] cause, code;
    logic pc_er, wr_er, dma_er, wr_or, dma_or;
    always_comb begin
        pc_er = bus.pc >= bus.ER_min && bus.pc <= bus.ER_max;
        wr_er = bus.data_wr && bus.data_addr >= bus.ER_min && bus.data_addr <= bus.ER_max;
        dma_er = bus.dma_en && bus.dma_addr >= bus.ER_min && bus.dma_addr <= bus.ER_max;
        wr_or = bus.data_wr && bus.data_addr >= bus.OR_min && bus.data_addr <= bus.OR_max;
        dma_or = bus.dma_en && bus.dma_addr >= bus.OR_min && bus.dma_addr <= bus.OR_max;
        code = state == KILL ? 3'd0 :
               (wr_er || dma_er) ? 3'd5 :
               (state == RUN && bus.dma_en) ? 3'd4 :
               (state == RUN && bus.irq) ? 3'd3 :
               (state == RUN && !pc_er && pc_prev != bus.ER_max) ? 3'd2 :
               (state == IDLE && pc_er && bus.pc != bus.ER_min) ? 3'd1 :
               ((wr_or && state != RUN) || dma_or) ? 3'd6 : 3'd0;
        // A RUN exit reaching the last branch is legal: an illegal one already produced a code
        state_nx = state == KILL ? (cnt <= CW'(1) ? IDLE : KILL) :
                   code != 3'd0 ? KILL :
                   state == IDLE ? (bus.pc == bus.ER_min ? RUN : IDLE) :
                   (pc_er ? RUN : IDLE);
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt <= '0;
            pc_prev <= '0;
            cause <= '0;
        end else begin
            state <= state_nx;
            pc_prev <= bus.pc;
            if (code != 3'd0) begin
                cnt <= CW'(ABORT_CYCLES);
                cause <= code;
            end else if (state == KILL) begin
                cnt <= cnt - CW'(1);
            end
        end
    end
    assign bus.viol = state == KILL;
    assign bus.in_er = state == RUN;
    assign bus.viol_cause = cause;
endmodule

// File: tb/tb_vape_exec_monitor.sv
// tb_vape_exec_monitor: vector table plus scoreboard for the execution monitor, and an ABORT_CYCLES=1 corner case
module tb_vape_exec_monitor;
    logic clk = 1'b0;
    logic reset_n, reset_n1;
    int errors = 0;
    int checks = 0;
    always #5 clk = ~clk;

    vape_exec_monitor_if bus ();
    vape_exec_monitor_if bus1 ();
    vape_exec_monitor #(.ABORT_CYCLES(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    vape_exec_monitor #(.ABORT_CYCLES(1)) dut1 (.clk(clk), .reset_n(reset_n1), .bus(bus1));

    typedef struct {
        logic        rst_n;
        logic [15:0] pc;
        logic        irq;
        logic        wr;
        logic [15:0] wa;
        logic        dma;
        logic [15:0] da;
        logic [4:0]  exp;
    } vec_t;
    vec_t tbl[$];
    logic [4:0] exp_q[$];

    function automatic logic [4:0] e(input logic v, input logic i, input logic [2:0] c);
        return {v, i, c};
    endfunction

    task automatic add(input logic r, input logic [15:0] p, input logic i, input logic w,
                       input logic [15:0] wa, input logic d, input logic [15:0] da, input logic [4:0] ex);
        tbl.push_back('{r, p, i, w, wa, d, da, ex});
    endtask

    task automatic idle_pc(input logic [15:0] p, input logic [4:0] ex);
        add(1'b1, p, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, ex);
    endtask

    initial begin
        logic [4:0] exp_v, act;
        bus.ER_min = 16'hE000; bus.ER_max = 16'hE0FE;
        bus.OR_min = 16'h0200; bus.OR_max = 16'h02FF;
        bus1.ER_min = 16'hE000; bus1.ER_max = 16'hE0FE;
        bus1.OR_min = 16'h0200; bus1.OR_max = 16'h02FF;
        bus1.pc = 16'hE010; bus1.irq = 1'b0; bus1.data_wr = 1'b0; bus1.data_addr = '0;
        bus1.dma_en = 1'b0; bus1.dma_addr = '0;
        reset_n1 = 1'b0;

        // normal entry, traversal and legal exit at ER_max
        add(1'b0, 16'hC000, 0, 0, 0, 0, 0, e(0, 0, 0));
        idle_pc(16'hC000, e(0, 0, 0));
        idle_pc(16'hE000, e(0, 1, 0));
        idle_pc(16'hE010, e(0, 1, 0));
        idle_pc(16'hE0FE, e(0, 1, 0));
        idle_pc(16'hC100, e(0, 0, 0));
        idle_pc(16'hC000, e(0, 0, 0));
        // mid entry: four-cycle pulse
        idle_pc(16'hE010, e(1, 0, 1));
        for (int k = 0; k < 3; k++) idle_pc(16'hC000, e(1, 0, 1));
        idle_pc(16'hC000, e(0, 0, 1));
        // irq and dma together in RUN; irq during KILL ignored
        idle_pc(16'hE000, e(0, 1, 1));
        add(1'b1, 16'hE020, 1, 0, 0, 1, 16'h1000, e(1, 0, 4));
        add(1'b1, 16'hC000, 1, 0, 0, 0, 0, e(1, 0, 4));
        add(1'b1, 16'hC000, 1, 0, 0, 0, 0, e(1, 0, 4));
        idle_pc(16'hC000, e(1, 0, 4));
        idle_pc(16'hC000, e(0, 0, 4));
        // illegal exit from the middle of ER
        idle_pc(16'hE000, e(0, 1, 4));
        idle_pc(16'hE020, e(0, 1, 4));
        idle_pc(16'hC000, e(1, 0, 2));
        for (int k = 0; k < 3; k++) idle_pc(16'hC000, e(1, 0, 2));
        idle_pc(16'hC000, e(0, 0, 2));
        // OR write outside RUN aborts, inside RUN is allowed
        add(1'b1, 16'hC000, 0, 1, 16'h0200, 0, 0, e(1, 0, 6));
        for (int k = 0; k < 3; k++) idle_pc(16'hC000, e(1, 0, 6));
        idle_pc(16'hC000, e(0, 0, 6));
        idle_pc(16'hE000, e(0, 1, 6));
        add(1'b1, 16'hE010, 0, 1, 16'h0200, 0, 0, e(0, 1, 6));
        idle_pc(16'hE000, e(0, 1, 6));
        idle_pc(16'hE0FE, e(0, 1, 6));
        idle_pc(16'hC100, e(0, 0, 6));
        // ER write in IDLE, then reset truncates the pulse
        add(1'b1, 16'hC000, 0, 1, 16'hE050, 0, 0, e(1, 0, 5));
        idle_pc(16'hC000, e(1, 0, 5));
        add(1'b0, 16'hC000, 0, 0, 0, 0, 0, e(0, 0, 0));
        idle_pc(16'hC000, e(0, 0, 0));
        // ER_min-1 while in RUN is an illegal exit
        idle_pc(16'hE000, e(0, 1, 0));
        idle_pc(16'hDFFF, e(1, 0, 2));
        for (int k = 0; k < 3; k++) idle_pc(16'hC000, e(1, 0, 2));
        idle_pc(16'hC000, e(0, 0, 2));
        // DMA into ER while in RUN: ER_WRITE outranks DMA
        idle_pc(16'hE000, e(0, 1, 2));
        add(1'b1, 16'hE010, 0, 0, 0, 1, 16'hE050, e(1, 0, 5));
        for (int k = 0; k < 3; k++) idle_pc(16'hC000, e(1, 0, 5));
        idle_pc(16'hC000, e(0, 0, 5));
        // DMA to OR in IDLE
        add(1'b1, 16'hC000, 0, 0, 0, 1, 16'h02FF, e(1, 0, 6));
        for (int k = 0; k < 3; k++) idle_pc(16'hC000, e(1, 0, 6));
        idle_pc(16'hC000, e(0, 0, 6));

        foreach (tbl[n]) begin
            reset_n = tbl[n].rst_n;
            bus.pc = tbl[n].pc;
            bus.irq = tbl[n].irq;
            bus.data_wr = tbl[n].wr;
            bus.data_addr = tbl[n].wa;
            bus.dma_en = tbl[n].dma;
            bus.dma_addr = tbl[n].da;
            exp_q.push_back(tbl[n].exp);
            @(posedge clk);
            #1;
            exp_v = exp_q.pop_front();
            act = {bus.viol, bus.in_er, bus.viol_cause};
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL vec%0d {viol,in_er,cause}: got %b expected %b", n, act, exp_v);
            end
        end

        // ABORT_CYCLES=1 held at a mid-ER address: alternating one-cycle pulses
        @(posedge clk);
        #1;
        reset_n1 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(e(k % 2 == 0, 0, 1));
            @(posedge clk);
            #1;
            exp_v = exp_q.pop_front();
            act = {bus1.viol, bus1.in_er, bus1.viol_cause};
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL abort1_cyc%0d {viol,in_er,cause}: got %b expected %b", k, act, exp_v);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
